// File: rtl/multicycle_datapath.sv
// Multicycle RV32I datapath: PC/OldPC/IR/MDR/ALUOut, 32x32 register file,
// immediate extender, ALU and source/result muxes around a unified async-read memory.
module multicycle_datapath #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pcwrite,
   input  logic        adrsource,
   input  logic        irwrite,
   input  logic        regwrite,
   input  logic        memwrite,
   input  logic [1:0]  imm_source,
   input  logic [1:0]  alu_source_a,
   input  logic [1:0]  alu_source_b,
   input  logic [2:0]  alu_control,
   input  logic [1:0]  resultsource,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic        func7_bit5,
   output logic        zero,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   localparam logic [1:0] SRCA_PC     = 2'b00;
   localparam logic [1:0] SRCA_OLD_PC = 2'b01;
   localparam logic [1:0] SRCA_RD1    = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALU     = 2'b00;
   localparam logic [1:0] RES_MDR     = 2'b01;
   localparam logic [1:0] RES_ALU_OUT = 2'b10;

   logic [31:0] pc;
   logic [31:0] old_pc;
   logic [31:0] ir;
   logic [31:0] mdr;
   logic [31:0] alu_out;
   logic [31:0] rf [0:31];

   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] imm_ext;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [31:0] alu_result;
   logic [31:0] result;

   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];
   assign rd  = ir[11:7];

   assign opcode     = ir[6:0];
   assign funct3     = ir[14:12];
   assign func7_bit5 = ir[30];

   // No write-through: a read in the write cycle sees the pre-edge value.
   assign rd1 = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
   assign rd2 = (rs2 == 5'd0) ? 32'h0 : rf[rs2];

   always_comb begin
      imm_ext = 32'h0;
      case (imm_source)
         IMM_I:   imm_ext = {{20{ir[31]}}, ir[31:20]};
         IMM_S:   imm_ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         IMM_B:   imm_ext = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         default: imm_ext = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      endcase
   end

   always_comb begin
      src_a = 32'h0;
      case (alu_source_a)
         SRCA_PC:     src_a = pc;
         SRCA_OLD_PC: src_a = old_pc;
         SRCA_RD1:    src_a = rd1;
         default:     src_a = 32'h0;
      endcase
   end

   always_comb begin
      src_b = 32'h0;
      case (alu_source_b)
         SRCB_RD2:  src_b = rd2;
         SRCB_IMM:  src_b = imm_ext;
         SRCB_FOUR: src_b = 32'd4;
         default:   src_b = 32'h0;
      endcase
   end

   always_comb begin
      alu_result = 32'h0;
      case (alu_control)
         ALU_ADD: alu_result = src_a + src_b;
         ALU_SUB: alu_result = src_a - src_b;
         ALU_AND: alu_result = src_a & src_b;
         ALU_OR:  alu_result = src_a | src_b;
         ALU_SLT: alu_result = ($signed(src_a) < $signed(src_b)) ? 32'h1 : 32'h0;
         default: alu_result = 32'h0;
      endcase
   end

   assign zero = (alu_result == 32'h0);

   always_comb begin
      result = 32'h0;
      case (resultsource)
         RES_ALU:     result = alu_result;
         RES_MDR:     result = mdr;
         RES_ALU_OUT: result = alu_out;
         default:     result = 32'h0;
      endcase
   end

   assign mem_addr  = adrsource ? result : pc;
   assign mem_wdata = rd2;
   assign mem_we    = memwrite;

   // MDR and ALUOut are free-running pipeline latches; the control unit relies on them
   // holding the previous cycle's values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= RESET_PC;
         old_pc  <= 32'h0;
         ir      <= 32'h0;
         mdr     <= 32'h0;
         alu_out <= 32'h0;
      end else begin
         if (pcwrite)
            pc <= result;
         if (irwrite) begin
            ir     <= mem_rdata;
            old_pc <= pc;
         end
         mdr     <= mem_rdata;
         alu_out <= alu_result;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++)
            rf[i] <= 32'h0;
      end else if (regwrite && (rd != 5'd0)) begin
         rf[rd] <= result;
      end
   end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: directed control sequences push expected
// outputs into a queue, a negedge monitor pops and compares them.
module tb_multicycle_datapath;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pcwrite, adrsource, irwrite, regwrite, memwrite;
   logic [1:0]  imm_source, alu_source_a, alu_source_b, resultsource;
   logic [2:0]  alu_control;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        func7_bit5;
   logic        zero;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   logic [31:0] mem [0:127];

   localparam int SEL_ADDR  = 0;
   localparam int SEL_WDATA = 1;
   localparam int SEL_ZERO  = 2;
   localparam int SEL_OP    = 3;
   localparam int SEL_WE    = 4;
   localparam int SEL_F3    = 5;
   localparam int SEL_F7    = 6;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;

   chk_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   multicycle_datapath #(.RESET_PC(32'h0000_0100)) dut (
      .clk          (clk),
      .reset        (reset),
      .pcwrite      (pcwrite),
      .adrsource    (adrsource),
      .irwrite      (irwrite),
      .regwrite     (regwrite),
      .memwrite     (memwrite),
      .imm_source   (imm_source),
      .alu_source_a (alu_source_a),
      .alu_source_b (alu_source_b),
      .alu_control  (alu_control),
      .resultsource (resultsource),
      .opcode       (opcode),
      .funct3       (funct3),
      .func7_bit5   (func7_bit5),
      .zero         (zero),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[8:2]];

   always @(posedge clk)
      if (mem_we) mem[mem_addr[8:2]] <= mem_wdata;

   // Monitor
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         chk_t        c;
         logic [31:0] act;
         c = sb_q.pop_front();
         case (c.sel)
            SEL_ADDR:  act = mem_addr;
            SEL_WDATA: act = mem_wdata;
            SEL_ZERO:  act = {31'h0, zero};
            SEL_OP:    act = {25'h0, opcode};
            SEL_WE:    act = {31'h0, mem_we};
            SEL_F3:    act = {29'h0, funct3};
            default:   act = {31'h0, func7_bit5};
         endcase
         checks++;
         if (act !== c.exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", c.name, act, c.exp, $time);
         end
      end
   end

   task automatic expect_out(input string n, input int sel, input logic [31:0] v);
      chk_t c;
      c.name = n;
      c.sel  = sel;
      c.exp  = v;
      sb_q.push_back(c);
   endtask

   task automatic ctl(input logic pw, input logic aw, input logic iw, input logic rw,
                      input logic mw, input logic [1:0] imm, input logic [1:0] sa,
                      input logic [1:0] sb, input logic [2:0] ac, input logic [1:0] rs);
      pcwrite = pw; adrsource = aw; irwrite = iw; regwrite = rw; memwrite = mw;
      imm_source = imm; alu_source_a = sa; alu_source_b = sb;
      alu_control = ac; resultsource = rs;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch();
      ctl(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
      step();
   endtask

   task automatic pc_inc();
      ctl(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00);
      step();
   endtask

   task automatic exec_i();
      ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
      step();
   endtask

   task automatic exec_r(input string n, input logic [2:0] ac, input logic z);
      ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ac, 2'b00);
      expect_out(n, SEL_ZERO, {31'h0, z});
      step();
   endtask

   task automatic wb(input string n, input logic [31:0] e);
      ctl(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10);
      expect_out(n, SEL_ADDR, e);
      step();
   endtask

   task automatic probe_regs(input string n, input logic [31:0] e1, input logic [31:0] e2);
      ctl(0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b11, 3'b000, 2'b00);
      expect_out({n, "_rd1"}, SEL_ADDR, e1);
      expect_out({n, "_rd2"}, SEL_WDATA, e2);
      step();
   endtask

   task automatic probe_alu(input string n, input logic [2:0] ac, input logic [31:0] e);
      ctl(0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, ac, 2'b00);
      expect_out({n, "_res"}, SEL_ADDR, e);
      expect_out({n, "_zero"}, SEL_ZERO, {31'h0, (e == 32'h0)});
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      mem[0]  = 32'h0050_0093;  // addi x1,x0,5
      mem[1]  = 32'h0070_0113;  // addi x2,x0,7
      mem[2]  = 32'h4020_81B3;  // sub  x3,x1,x2
      mem[3]  = 32'h0020_A233;  // slt  x4,x1,x2
      mem[4]  = 32'h0041_E333;  // or   x6,x3,x4
      mem[5]  = 32'h0010_2423;  // sw   x1,8(x0)
      mem[6]  = 32'h0080_2103;  // lw   x2,8(x0)
      mem[7]  = 32'h4020_82B3;  // sub  x5,x1,x2
      mem[8]  = 32'h0090_0013;  // addi x0,x0,9
      mem[9]  = 32'h0010_63B3;  // or   x7,x0,x1
      mem[10] = 32'h0030_0413;  // addi x8,x0,3
      mem[64] = 32'h4020_81B3;  // sub  x3,x1,x2 at 0x100

      ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
      #1 reset = 1'b0;
      expect_out("rst_opcode", SEL_OP, 32'h0);
      expect_out("rst_pc", SEL_ADDR, 32'h100);
      expect_out("rst_we", SEL_WE, 32'h0);
      step();
      step();
      reset = 1'b1;

      fetch();
      expect_out("rst_f7", SEL_F7, 32'h1);
      probe_regs("rst_x1x2", 32'h0, 32'h0);

      ctl(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11);
      step();

      // addi x1,x0,5
      fetch(); pc_inc(); exec_i(); wb("addi_x1", 32'd5);
      expect_out("addi_opcode", SEL_OP, 32'h13);
      ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
      expect_out("addi_pc", SEL_ADDR, 32'd4);
      step();
      ctl(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b11, 3'b000, 2'b00);
      expect_out("addi_oldpc", SEL_ADDR, 32'd0);
      step();

      // addi x2,x0,7
      fetch(); pc_inc(); exec_i(); wb("addi_x2", 32'd7);

      // sub x3,x1,x2
      fetch(); pc_inc();
      probe_regs("sub_src", 32'd5, 32'd7);
      exec_r("sub_zero", 3'b001, 1'b0);
      wb("sub_x3", 32'hFFFF_FFFE);

      // slt x4,x1,x2
      fetch(); pc_inc();
      expect_out("slt_f3", SEL_F3, 32'd2);
      exec_r("slt_zero", 3'b101, 1'b0);
      wb("slt_x4", 32'd1);

      // or x6,x3,x4
      fetch(); pc_inc();
      probe_regs("or_src", 32'hFFFF_FFFE, 32'd1);
      exec_r("or_zero", 3'b011, 1'b0);
      wb("or_x6", 32'hFFFF_FFFF);

      // sw x1,8(x0)
      fetch(); pc_inc();
      ctl(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 3'b000, 2'b00);
      step();
      ctl(0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10);
      expect_out("sw_addr", SEL_ADDR, 32'd8);
      expect_out("sw_wdata", SEL_WDATA, 32'd5);
      expect_out("sw_we", SEL_WE, 32'd1);
      step();

      // lw x2,8(x0)
      fetch(); pc_inc(); exec_i();
      ctl(0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
      expect_out("lw_addr", SEL_ADDR, 32'd8);
      step();
      ctl(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
      expect_out("lw_mdr", SEL_ADDR, 32'd5);
      step();

      // sub x5,x1,x2 with equal operands
      fetch(); pc_inc();
      probe_regs("sub_eq_src", 32'd5, 32'd5);
      exec_r("sub_eq_zero", 3'b001, 1'b1);
      wb("sub_eq_x5", 32'd0);

      // addi x0,x0,9 must be discarded
      fetch(); pc_inc(); exec_i(); wb("addi_x0_res", 32'd9);

      // or x7,x0,x1 reads x0 back, plus ALU code sweep on (0, 5)
      fetch(); pc_inc();
      probe_regs("x0_read", 32'h0, 32'd5);
      probe_alu("alu_111", 3'b111, 32'h0);
      probe_alu("alu_or", 3'b011, 32'd5);
      probe_alu("alu_and", 3'b010, 32'h0);
      probe_alu("alu_slt", 3'b101, 32'd1);

      // addi x8,x0,3 interrupted by reset
      fetch(); pc_inc(); exec_i();
      ctl(0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b10);
      expect_out("pre_rst_aluout", SEL_ADDR, 32'd3);
      step();
      reset = 1'b0;
      expect_out("mid_rst_aluout", SEL_ADDR, 32'h0);
      expect_out("mid_rst_opcode", SEL_OP, 32'h0);
      step();
      ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
      expect_out("mid_rst_pc", SEL_ADDR, 32'h100);
      step();
      reset = 1'b1;
      fetch();
      probe_regs("post_rst_x1x2", 32'h0, 32'h0);

      step();
      step();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Multicycle RV32I datapath that executes the control signals produced by the multicycle control unit and returns the decode fields and ALU `zero` flag to it. It holds the architectural state and the inter-cycle registers: PC, OldPC, IR, MDR, ALUOut and a 32x32 register file. It also contains the immediate extender, the ALU, and the source and result multiplexers. It connects directly to a single-port, asynchronous-read unified instruction/data memory.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pcwrite`, `adrsource`, `irwrite`, `regwrite`, `memwrite` in 1 each: control strobes from the control unit.
- `imm_source` in 2: 00 I, 01 S, 10 B, 11 J.
- `alu_source_a` in 2: 00 PC, 01 OldPC, 10 RD1, 11 constant 0.
- `alu_source_b` in 2: 00 RD2, 01 ImmExt, 10 constant 4, 11 constant 0.
- `alu_control` in 3: 000 add, 001 sub, 010 and, 011 or, 101 slt; other codes give result 0.
- `resultsource` in 2: 00 ALUResult (direct), 01 MDR, 10 ALUOut, 11 constant 0.
- `opcode` out 7: IR[6:0].
- `funct3` out 3: IR[14:12].
- `func7_bit5` out 1: IR[30].
- `zero` out 1: combinational; high when ALUResult == 0.
- `mem_addr` out 32: `adrsource` ? Result : PC.
- `mem_wdata` out 32: RD2.
- `mem_we` out 1: equal to `memwrite`.
- `mem_rdata` in 32: memory read data, valid in the same cycle as `mem_addr`.

## Operation
- The register file has two combinational read ports: RD1 = x[IR[19:15]], RD2 = x[IR[24:20]].
  - x0 always reads 0.
  - A write with rd = 0 is discarded.
  - Write: on a clock edge with `regwrite` = 1, x[IR[11:7]] <= Result.
- PC: on an edge with `pcwrite` = 1, PC <= Result.
- IR and OldPC: on an edge with `irwrite` = 1, IR <= `mem_rdata` and OldPC <= PC (pre-edge PC).
- MDR <= `mem_rdata` on every edge (unconditional).
- ALUOut <= ALUResult on every edge (unconditional).
- Immediate extension, all sign-extended to 32 bits:
  - I: IR[31:20].
  - S: {IR[31:25], IR[11:7]}.
  - B: {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
  - J: {IR[31], IR[19:12], IR[20], IR[30:21], 0}.
- ALU:
  - add and sub are 32-bit modulo; overflow is ignored.
  - slt is a signed compare, giving 32'h1 or 32'h0.
  - and and or are bitwise.
- Result is purely combinational from `resultsource`.
- Supported control sequences:
  - Fetch: `adrsource` = 0, then `irwrite`.
  - Load: address = ALUResult (`resultsource` 00, `adrsource` 1), MDR captured on that edge; next cycle `resultsource` 01 + `regwrite`.
  - Store: address from ALUOut (`resultsource` 10, `adrsource` 1) with `memwrite`; write data is RD2.
  - Register writeback: `resultsource` 10 + `regwrite`.
  - PC increment: OldPC + 4 with `resultsource` 00 + `pcwrite`.

## Timing
- Reset (`reset` = 0, asynchronous) sets:
  - PC = `RESET_PC`; OldPC = 0; IR = 0; MDR = 0; ALUOut = 0; all registers x1..x31 = 0.
  - Outputs under reset: `opcode` = 0, `funct3` = 0, `func7_bit5` = 0, `mem_we` = `memwrite`, `mem_addr` = PC or Result per `adrsource`.
- Reset deassertion is synchronised externally; the first edge after release may update state.
- All writes take effect at the edge and are visible combinationally in the following cycle. Reads in the write cycle return the old value; there is no bypass.
- Simultaneous `pcwrite` and `irwrite`: OldPC receives the old PC and IR receives memory data addressed by the old PC or Result (per `adrsource`).
- Simultaneous `regwrite` and a read of the same register: reads return the old value in that cycle.
- Reset asserted mid-instruction: every register clears immediately. Memory contents are untouched. A `memwrite` in progress is gated only by the control unit.
- Latency:
  - `zero`, `mem_addr`, `mem_wdata` and the decode fields are combinational from current state and controls.
  - No output is more than one edge behind its source.

## Test plan
- Reset: hold `reset` = 0 with `RESET_PC` = 0x100 → PC = 0x100, `opcode` = 0, x1..x31 read 0; `mem_addr` = 0x100 with `adrsource` = 0.
- Drive fetch, execute, writeback and PC+4 for addi x1,x0,5 (0x00500093) at PC = 0 → x1 = 5, PC = 4, OldPC = 0, `opcode` = 0010011.
- With x1 = 5 and x2 = 7, R-type sub x3,x1,x2 then slt x4,x1,x2 → x3 = 0xFFFF_FFFE and x4 = 1. A sub with equal operands gives `zero` = 1.
- Store then load:
  - sw x1,8(x0) (0x00102423) → at MEMORY_ACCESS, `mem_addr` = 8, `mem_wdata` = 5, `mem_we` = 1.
  - lw x2,8(x0) (0x00802103) with `mem_rdata` = 5 → x2 = 5.
- addi x0,x0,9 with `regwrite` → x0 still reads 0. Also `alu_control` = 111 → result 0, `zero` = 1.
- Assert `reset` asynchronously between edges in the middle of an addi → PC, IR and ALUOut clear before the next edge; the register file clears.
